snow64_long_mul_u16_by_u8_radix_16: RTL and testbench

Sequential radix-16 multiply-accumulate unit computing the 24-bit value a × b + c from a 16-bit unsigned a, an 8-bit unsigned b and an optional 8-bit unsigned addend c. It is the reconstruction counterpart of the u16-by-u8 radix-16 long divider: given quotient, divisor and remainder, it rebuilds the dividend. It uses the same start/valid/can-accept command handshake, so a requester can drive the divider and this unit interchangeably. It sits beside the divider in the Snow64 integer/fixed-point support path.

---
 rtl/snow64_long_mul_u16_by_u8_radix_16_pkg.sv | 28 ++
 rtl/snow64_long_mul_u16_by_u8_radix_16_if.sv | 44 ++++
 rtl/snow64_radix_16_multiple_table.sv | 38 +++
 rtl/snow64_long_mul_u16_by_u8_radix_16.sv | 114 +++++++++++
 tb/tb_snow64_long_mul_u16_by_u8_radix_16.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/snow64_long_mul_u16_by_u8_radix_16_pkg.sv
// ----------------------------------------------------------------------------
// snow64_long_mul_u16_by_u8_radix_16_pkg
// Shared constants and types for the radix-16 u16 x u8 multiply-accumulate
// unit. This is the reconstruction partner of the u16-by-u8 radix-16 divider.
// Holds operand/result widths, radix constants and the FSM state type.
// ----------------------------------------------------------------------------
package snow64_long_mul_u16_by_u8_radix_16_pkg;

  localparam int WIDTH__IN_A       = 16;
  localparam int MSB_POS__IN_A     = WIDTH__IN_A - 1;
  localparam int WIDTH__IN_B       = 8;
  localparam int MSB_POS__IN_B     = WIDTH__IN_B - 1;
  localparam int WIDTH__IN_C       = 8;
  localparam int MSB_POS__IN_C     = WIDTH__IN_C - 1;
  localparam int WIDTH__OUT_DATA   = 24;
  localparam int MSB_POS__OUT_DATA = WIDTH__OUT_DATA - 1;
  localparam int WIDTH__MULT_ARR   = 12;
  localparam int MSB_POS__MULT_ARR = WIDTH__MULT_ARR - 1;

  localparam int RADIX              = 16;
  localparam int BITS_PER_ITERATION = 4;

  typedef enum logic {
    StIdle    = 1'b0,
    StWorking = 1'b1
  } state_t;

endpackage

// File: rtl/snow64_long_mul_u16_by_u8_radix_16_if.sv
// ----------------------------------------------------------------------------
// snow64_long_mul_u16_by_u8_radix_16_if
// Command/result bundle shared with the radix-16 long divider, so a requester
// can drive either unit.
//   master : requester (drives in_*, observes out_*)
//   slave  : the multiply-accumulate unit
// Signals: in_start, in_a[15:0], in_b[7:0], in_c[7:0] (only with
// SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN), out_data_valid, out_can_accept_cmd,
// out_data[23:0].
// ----------------------------------------------------------------------------
interface snow64_long_mul_u16_by_u8_radix_16_if;
  import snow64_long_mul_u16_by_u8_radix_16_pkg::*;

  logic                     in_start;
  logic [MSB_POS__IN_A:0]   in_a;
  logic [MSB_POS__IN_B:0]   in_b;
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
  logic [MSB_POS__IN_C:0]   in_c;
`endif
  logic                     out_data_valid;
  logic                     out_can_accept_cmd;
  logic [MSB_POS__OUT_DATA:0] out_data;

`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
  modport master (
    output in_start, in_a, in_b, in_c,
    input  out_data_valid, out_can_accept_cmd, out_data
  );
  modport slave (
    input  in_start, in_a, in_b, in_c,
    output out_data_valid, out_can_accept_cmd, out_data
  );
`else
  modport master (
    output in_start, in_a, in_b,
    input  out_data_valid, out_can_accept_cmd, out_data
  );
  modport slave (
    input  in_start, in_a, in_b,
    output out_data_valid, out_can_accept_cmd, out_data
  );
`endif

endinterface

// File: rtl/snow64_radix_16_multiple_table.sv
// ----------------------------------------------------------------------------
// snow64_radix_16_multiple_table
// Registered table of the sixteen multiples b*k (k = 0..15) of the 8-bit
// multiplier, loaded on a strobe so each working cycle needs only a mux.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (table cleared)
//   i_load in   load strobe; table captures multiples of i_b
//   i_b    in   8-bit multiplier
//   o_mult out  16 x 12-bit multiples, o_mult[k] = i_b * k
// ----------------------------------------------------------------------------
module snow64_radix_16_multiple_table
  import snow64_long_mul_u16_by_u8_radix_16_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_load,
  input  logic [MSB_POS__IN_B:0]                   i_b,
  output logic [RADIX-1:0][MSB_POS__MULT_ARR:0]    o_mult
);

  logic [RADIX-1:0][MSB_POS__MULT_ARR:0] r_mult;

  // NOTE: this small table is reset because the reset state is specified as
  // all-zero; a large RAM-style array would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mult <= '0;
    end else if (i_load) begin
      for (int k = 0; k < RADIX; k++) begin
        r_mult[k] <= WIDTH__MULT_ARR'(i_b) * WIDTH__MULT_ARR'(k);
      end
    end
  end

  assign o_mult = r_mult;

endmodule

// File: rtl/snow64_long_mul_u16_by_u8_radix_16.sv
// ----------------------------------------------------------------------------
// snow64_long_mul_u16_by_u8_radix_16
// Sequential radix-16 multiply-accumulate: out_data = a * b (+ c).
// One 4-bit digit of a per cycle, most-significant first; 4 working cycles
// after the accepting edge, 5 cycles per operation.
// Optional feature macro: SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
//   defined   -> in_c exists, result is a*b + c
//   undefined -> no in_c, result is a*b (same latency)
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of snow64_long_mul_u16_by_u8_radix_16_if
// ----------------------------------------------------------------------------
module snow64_long_mul_u16_by_u8_radix_16
  import snow64_long_mul_u16_by_u8_radix_16_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  snow64_long_mul_u16_by_u8_radix_16_if.slave   bus
);

  state_t                              r_state;
  logic [MSB_POS__IN_A:0]              r_a;
  logic [MSB_POS__OUT_DATA:0]          r_acc;
  logic [1:0]                          r_i;
  logic [MSB_POS__OUT_DATA:0]          r_data;
  logic                                r_valid;
  logic                                r_can_accept;

  logic                                w_accept;
  logic [RADIX-1:0][MSB_POS__MULT_ARR:0] w_mult;
  logic [BITS_PER_ITERATION-1:0]       w_digit;
  logic [MSB_POS__IN_C:0]              w_addend;
  logic [MSB_POS__OUT_DATA:0]          w_next_acc;

`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
  logic [MSB_POS__IN_C:0]              r_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_c <= '0;
    else if (w_accept) r_c <= bus.in_c;
  end

  assign w_addend = r_c;
`else
  assign w_addend = '0;
`endif

  assign w_accept = (r_state == StIdle) && bus.in_start;

  snow64_radix_16_multiple_table u_table (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_b    (bus.in_b),
    .o_mult (w_mult)
  );

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_digit    = '0;
    w_next_acc = '0;
    w_digit    = r_a[{r_i, 2'b00} +: BITS_PER_ITERATION];
    // Addend joins only on the last digit so it lands unshifted.
    w_next_acc = (r_acc << BITS_PER_ITERATION)
               + WIDTH__OUT_DATA'(w_mult[w_digit])
               + ((r_i == 2'd0) ? WIDTH__OUT_DATA'(w_addend) : '0);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_a          <= '0;
      r_acc        <= '0;
      r_i          <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_can_accept <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_start) begin
            r_a          <= bus.in_a;
            r_acc        <= '0;
            r_i          <= 2'd3;
            r_valid      <= 1'b0;
            r_can_accept <= 1'b0;
            r_state      <= StWorking;
          end
        end
        StWorking: begin
          r_acc <= w_next_acc;
          if (r_i == 2'd0) begin
            r_data       <= w_next_acc;
            r_valid      <= 1'b1;
            r_can_accept <= 1'b1;
            r_state      <= StIdle;
          end else begin
            r_i <= r_i - 2'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.out_data           = r_data;
  assign bus.out_data_valid     = r_valid;
  assign bus.out_can_accept_cmd = r_can_accept;

endmodule

// File: tb/tb_snow64_long_mul_u16_by_u8_radix_16.sv
// ----------------------------------------------------------------------------
// tb_snow64_long_mul_u16_by_u8_radix_16
// Directed self-checking bench for the radix-16 multiply-accumulate unit.
// Works in both builds; expected values follow
// SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_snow64_long_mul_u16_by_u8_radix_16;

`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
  localparam bit ADDEND = 1'b1;
`else
  localparam bit ADDEND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  snow64_long_mul_u16_by_u8_radix_16_if bus ();

  snow64_long_mul_u16_by_u8_radix_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%06h expected 0x%06h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] c);
    bus.in_a = a;
    bus.in_b = b;
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
    bus.in_c = c;
`else
    if (c != 8'd0) begin end
`endif
  endtask

  // Start at next edge N, check busy/valid timing, result after edge N+4.
  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [7:0] b, input logic [7:0] c,
                        input logic [23:0] exp, input bit full);
    set_ops(a, b, c);
    bus.in_start = 1'b1;
    @(posedge clk);                 // edge N
    @(negedge clk);
    bus.in_start = 1'b0;
    set_ops(16'hDEAD, 8'hBE, 8'hEF); // don't-care after acceptance
    if (full) begin
      check({tag, " busy"},  24'(bus.out_can_accept_cmd), 24'd0);
      check({tag, " vclr"},  24'(bus.out_data_valid),     24'd0);
    end
    repeat (3) @(posedge clk);      // edges N+1..N+3
    @(negedge clk);
    if (full) check({tag, " early"}, 24'(bus.out_data_valid), 24'd0);
    @(posedge clk);                 // edge N+4
    @(negedge clk);
    check({tag, " data"}, bus.out_data, exp);
    if (full) begin
      check({tag, " valid"}, 24'(bus.out_data_valid),     24'd1);
      check({tag, " idle"},  24'(bus.out_can_accept_cmd), 24'd1);
    end
  endtask

  logic [15:0] ra;
  logic [7:0]  rb;
  logic [7:0]  rc;
  logic [23:0] rexp;

  initial begin
    bus.in_start = 1'b0;
    set_ops('0, '0, '0);

    // Reset state
    #12;
    check("rst data",   bus.out_data,                   24'd0);
    check("rst valid",  24'(bus.out_data_valid),        24'd0);
    check("rst accept", 24'(bus.out_can_accept_cmd),    24'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    run_op("v1000x7", 16'd1000, 8'd7, 8'd5,
           ADDEND ? 24'h001B5D : 24'h001B58, 1'b1);

    // Result holds while idle
    repeat (3) @(negedge clk);
    check("hold data",  bus.out_data,                ADDEND ? 24'h001B5D : 24'h001B58);
    check("hold valid", 24'(bus.out_data_valid),     24'd1);
    check("hold idle",  24'(bus.out_can_accept_cmd), 24'd1);

    run_op("max",  16'hFFFF, 8'hFF, 8'hFF,
           ADDEND ? 24'hFF0000 : 24'hFEFF01, 1'b1);
    run_op("b0",   16'h1234, 8'h00, 8'h2A,
           ADDEND ? 24'h00002A : 24'h000000, 1'b1);
    run_op("a0",   16'h0000, 8'h80, 8'h00, 24'h000000, 1'b1);
    run_op("digs", 16'h8421, 8'h03, 8'h10,
           ADDEND ? 24'h018C73 : 24'h018C63, 1'b1);

    // in_start held high; operands changed mid-operation
    set_ops(16'd3, 8'd5, 8'd1);
    bus.in_start = 1'b1;
    @(posedge clk);                 // edge N
    @(negedge clk);
    set_ops(16'd10, 8'd10, 8'd2);
    repeat (4) @(posedge clk);      // edges N+1..N+4
    @(negedge clk);
    check("hold1 data",  bus.out_data, ADDEND ? 24'd16 : 24'd15);
    check("hold1 valid", 24'(bus.out_data_valid), 24'd1);
    @(posedge clk);                 // edge N+5: second start accepted
    @(negedge clk);
    check("hold2 vclr", 24'(bus.out_data_valid),     24'd0);
    check("hold2 busy", 24'(bus.out_can_accept_cmd), 24'd0);
    check("hold2 keep", bus.out_data, ADDEND ? 24'd16 : 24'd15);
    bus.in_start = 1'b0;
    repeat (3) @(posedge clk);      // edges N+6..N+8
    @(negedge clk);
    check("hold2 early", 24'(bus.out_data_valid), 24'd0);
    @(posedge clk);                 // edge N+9
    @(negedge clk);
    check("hold2 data",  bus.out_data, ADDEND ? 24'd102 : 24'd100);
    check("hold2 valid", 24'(bus.out_data_valid), 24'd1);

    // Asynchronous reset mid-operation
    set_ops(16'h0101, 8'h11, 8'h01);
    bus.in_start = 1'b1;
    @(posedge clk);                 // edge N
    @(negedge clk);
    bus.in_start = 1'b0;
    @(posedge clk);                 // edge N+1
    @(posedge clk);                 // edge N+2
    #1 rst = 1'b1;
    #1;
    check("arst data",   bus.out_data,                24'd0);
    check("arst valid",  24'(bus.out_data_valid),     24'd0);
    check("arst accept", 24'(bus.out_can_accept_cmd), 24'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("arst nopulse", 24'(bus.out_data_valid), 24'd0);
    end
    run_op("post rst", 16'd1000, 8'd7, 8'd5,
           ADDEND ? 24'h001B5D : 24'h001B58, 1'b1);

    // Random sweep against a reference model
    for (int n = 0; n < 2000; n++) begin
      ra   = 16'($urandom);
      rb   = 8'($urandom);
      rc   = 8'($urandom);
      rexp = 24'(ra) * 24'(rb) + (ADDEND ? 24'(rc) : 24'd0);
      run_op("rand", ra, rb, rc, rexp, (n % 64) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
